// File: rtl/spi_tx_scheduler.sv
// Round-robin scheduler that loads one requester's word plus a microsecond timestamp for the SPI slave.
// Optional LOADED-state packet timeout is built when SCHED_TIMEOUT_EN is defined.
module spi_tx_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic                   clk2x,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [32*NREQ-1:0]     req_data,
  input  logic                   us_tick,
  input  logic                   ssel,
  output logic [NREQ-1:0]        grant,
  output logic [31:0]            dec_pack,
  output logic [31:0]            time_us,
  output logic                   pack_valid,
  output logic [2:0]             src_id,
  output logic [7:0]             drop_cnt
);

  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 3;
  localparam int unsigned MAXRQ = 8;

  if (NREQ < 2 || NREQ > MAXRQ || TIMEOUT == 16'd0) begin : g_param_check
    $error("spi_tx_scheduler: NREQ must be 2..8 and TIMEOUT non-zero");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_SEND   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [31:0]     us_cnt;
  logic            ssel_meta, ssel_sync, ssel_prev;
  logic            frame_start_c, frame_end_c;
  logic [IW-1:0]   last, last_d;
  logic [NREQ-1:0] grant_d;
  logic [DW-1:0]   dec_pack_d, time_us_d;
  logic [IW-1:0]   src_id_d;
  logic            pack_valid_d;
  logic [DW-1:0]   words [MAXRQ];
  logic [15:0]     req_ext;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [3:0]      cand;

  // Free-running timestamp, wraps naturally at 2^32
  always_ff @(negedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      us_cnt <= '0;
    end else if (us_tick) begin
      us_cnt <= us_cnt + 32'd1;
    end
  end

  // Two-flop synchroniser plus edge register; idle level is high
  always_ff @(negedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      ssel_meta <= 1'b1;
      ssel_sync <= 1'b1;
      ssel_prev <= 1'b1;
    end else begin
      ssel_meta <= ssel;
      ssel_sync <= ssel_meta;
      ssel_prev <= ssel_sync;
    end
  end

  assign frame_start_c = ssel_prev & ~ssel_sync;
  assign frame_end_c   = ~ssel_prev & ssel_sync;

  // Unpack the flat data bus into a fixed 8-entry table indexed by a 3-bit id
  always_comb begin
    for (int unsigned i = 0; i < MAXRQ; i++) begin
      words[i] = '0;
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      words[i] = req_data[DW*i +: DW];
    end
  end

  assign req_ext = 16'(req);

  // Round-robin: scan downward so the lowest offset after 'last' wins
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      cand = 4'({1'b0, last}) + 4'(k);
      if (cand >= 4'(NREQ)) begin
        cand = cand - 4'(NREQ);
      end
      if (req_ext[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  logic [15:0] to_cnt, to_cnt_d;
  logic [7:0]  drop_cnt_d;
`endif

  // Next-state and registered-output values
  always_comb begin
    state_d      = state;
    last_d       = last;
    grant_d      = '0;
    dec_pack_d   = dec_pack;
    time_us_d    = time_us;
    src_id_d     = src_id;
    pack_valid_d = pack_valid;
`ifdef SCHED_TIMEOUT_EN
    to_cnt_d     = to_cnt;
    drop_cnt_d   = drop_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          dec_pack_d   = words[pick_idx];
          time_us_d    = us_cnt;
          src_id_d     = pick_idx;
          last_d       = pick_idx;
          grant_d      = NREQ'(1) << pick_idx;
          pack_valid_d = 1'b1;
          state_d      = ST_LOADED;
`ifdef SCHED_TIMEOUT_EN
          to_cnt_d     = '0;
`endif
        end
      end
      ST_LOADED: begin
        if (frame_start_c) begin
          state_d = ST_SEND;
`ifdef SCHED_TIMEOUT_EN
        end else if (to_cnt == TIMEOUT - 16'd1) begin
          pack_valid_d = 1'b0;
          state_d      = ST_IDLE;
          if (drop_cnt != 8'hFF) begin
            drop_cnt_d = drop_cnt + 8'd1;
          end
        end else begin
          to_cnt_d = to_cnt + 16'd1;
`endif
        end
      end
      ST_SEND: begin
        if (frame_end_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        pack_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(negedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last       <= IW'(NREQ - 1);
      grant      <= '0;
      dec_pack   <= 32'hFFFF_FFFF;
      time_us    <= 32'hFFFF_FFFF;
      src_id     <= '0;
      pack_valid <= 1'b0;
    end else begin
      state      <= state_d;
      last       <= last_d;
      grant      <= grant_d;
      dec_pack   <= dec_pack_d;
      time_us    <= time_us_d;
      src_id     <= src_id_d;
      pack_valid <= pack_valid_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(negedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      to_cnt   <= to_cnt_d;
      drop_cnt <= drop_cnt_d;
    end
  end
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: doc/spi_tx_scheduler.md
# spi_tx_scheduler

Round-robin scheduler that shares the SPI slave's 32-bit transmit payload between several data sources. It keeps a free-running microsecond timestamp and grants one requester at a time. It latches that requester's word together with a capture timestamp onto the slave's `decPack`/`timeUs` inputs, then holds the pair stable until the SPI master has clocked out one complete chip-select frame. It sits between the decoder/sensor producers and the SPI slave, on the same `clk2x` domain.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 16'd50000: `clk2x` cycles allowed in LOADED before a frame must start. Used only with `SCHED_TIMEOUT_EN`.
- `clk2x`  in  1  system clock; all registers update on its falling edge, as the SPI slave does.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  level request per source; the source holds it until granted.
- `req_data`  in  32*NREQ  flat data bus; source i occupies bits [32i+31:32i].
- `us_tick`  in  1  one-cycle strobe, once per microsecond.
- `ssel`  in  1  raw SPI chip select, active low; synchronised internally.
- `grant`  out  NREQ  one-hot, one-cycle pulse: that source's word has been captured.
- `dec_pack`  out  32  payload to the slave's `decPack` input.
- `time_us`  out  32  capture timestamp to the slave's `timeUs` input.
- `pack_valid`  out  1  high while a payload is loaded and not yet sent.
- `src_id`  out  3  index of the source currently loaded.
- `drop_cnt`  out  8  count of packets discarded by timeout; saturates at 255.

## Operation
- **Timestamp counter.** A 32-bit `us_cnt` increments on `us_tick` and wraps from 0xFFFFFFFF to 0.
- **ssel handling.** `ssel` passes through a 2-flop synchroniser plus an edge register. `start` is the synced falling edge; `end` is the synced rising edge.
- **IDLE.** If `req != 0`, choose the first set bit searching upward from `last+1` and wrapping. `last` resets to NREQ-1, so after reset source 0 has priority. On the choice:
  - capture `req_data[i]` into `dec_pack`;
  - capture `us_cnt` into `time_us`, using the pre-increment value if `us_tick` arrives the same cycle;
  - set `src_id=i` and `last=i`;
  - pulse `grant[i]` for one cycle;
  - go to LOADED.
- **LOADED.** `pack_valid=1`. On `start`, go to SEND.
  - If `ssel` was already low on entry, no `start` exists for that frame. The in-progress frame is ignored and the block waits for the next falling edge.
- **SEND.** `pack_valid=1`; `dec_pack`, `time_us` and `src_id` are frozen. On `end`, go to DONE.
- **DONE.** One cycle; clear `pack_valid`; go to IDLE. A new grant is possible at the earliest on the cycle after DONE.
- **Held outputs.** `dec_pack`, `time_us` and `src_id` change only at a grant or at reset.
- **Request withdrawal.** A request dropped before it is granted is simply not served. There is no error.
- **Simultaneous requests.** Exactly one grant per IDLE pass. Round-robin guarantees each persistent requester service within NREQ frames.

## Timing
- **Reset values:**
  - `dec_pack` = 0xFFFFFFFF and `time_us` = 0xFFFFFFFF (the slave's idle pattern);
  - `grant` = 0, `pack_valid` = 0, `src_id` = 0, `drop_cnt` = 0, `us_cnt` = 0;
  - state = IDLE; synchroniser flops = 1 (ssel inactive).
- **Request to grant.** `req` sampled high in IDLE gives `grant` plus updated outputs on the next falling edge (1 cycle). `pack_valid` rises on the same edge.
- **ssel to state change.** A raw `ssel` edge reaches the state machine 3 cycles later (2 sync + 1 edge).
- **Back-to-back frames.** Frame end, then DONE (1 cycle), then IDLE (1 cycle) gives the earliest next grant 5 cycles after the raw `ssel` rise.
- **Reset mid-operation.** Asynchronous assertion forces the reset values immediately. The loaded packet is lost and is not counted in `drop_cnt`.

## Configuration
- **`SCHED_TIMEOUT_EN` defined:**
  - a 16-bit cycle counter runs in LOADED;
  - when it reaches `TIMEOUT` with no `start`, the packet is discarded: `pack_valid` clears, `drop_cnt` increments (saturating), and the state returns to IDLE;
  - the counter clears on every entry to LOADED;
  - SEND is never timed out.
- **`SCHED_TIMEOUT_EN` undefined:** LOADED waits indefinitely. `drop_cnt` is tied to 0 and no counter is built.

## Test plan
- Reset, then `req`=0001 with `req_data[0]`=0x12345678 and `us_cnt`=5 → `grant`=0001 for 1 cycle, `dec_pack`=0x12345678, `time_us`=5, `src_id`=0, `pack_valid`=1.
- `req`=1111 held, 4 frames of `ssel` low for 64 cycles then high → grants in order 0,1,2,3, one per frame. `pack_valid` falls 4 cycles after each `ssel` rise.
- Load a packet, then toggle `req_data` during SEND → `dec_pack` unchanged until after DONE.
- `us_cnt`=0xFFFFFFFF with `us_tick` and grant in the same cycle → `time_us`=0xFFFFFFFF and `us_cnt`=0 next cycle.
- With `SCHED_TIMEOUT_EN` and `TIMEOUT`=100, load a packet and keep `ssel` high → `pack_valid` drops at cycle 100 and `drop_cnt`=1. Repeating 300 times → `drop_cnt`=255.
- Assert `rst_n`=0 mid-SEND → all outputs at reset values immediately. After release, `req`=0100 → `grant`=0100.
